// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-input mux round-robin arbiter.
//   state_t    : arbiter state encoding (IDLE / GRANT)
//   SEL_W      : width of the mux select
//   NREQ       : number of requesters (mux inputs)
//   TO_W       : width of the optional grant wait counter
//   sel_onehot : select index to one-hot grant vector
package mux4_arb_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned TO_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NREQ'(1) << sel;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// rr_pick4: combinational rotating-priority picker.
//   req  in  4 : request vector
//   ptr  in  2 : index with highest priority this round
//   pick out 2 : first set request scanning ptr, ptr+1, ... modulo 4
//   any  out 1 : at least one request is set
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    // Scan from the farthest offset down so the closest set request wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        pick = ptr;
        idx  = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of the 4:1 mux select.
// Picks one requester per transaction, holds the select until the consumer
// takes the data (valid & ready), the requester drops its line, or (when
// MUX4_ARB_TIMEOUT_EN is defined) the grant has stalled TIMEOUT_CYCLES cycles.
//   clock   in  1 : clock, rising edge
//   reset_n in  1 : asynchronous active-low reset
//   req     in  4 : request per mux input (0=A .. 3=D)
//   ready   in  1 : consumer accepts the mux output
//   control out 2 : mux select, registered
//   grant   out 4 : one-hot of control while valid, else 0
//   valid   out 1 : mux output is being offered
//   timeout out 1 : one-cycle pulse when a stalled grant is abandoned
// Optional feature macro: MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic             ready,
    output logic [SEL_W-1:0] control,
    output logic [NREQ-1:0]  grant,
    output logic             valid,
    output logic             timeout
);

    // Reject out-of-range timeouts at elaboration.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..15");
    end

    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] control_d;
    logic [NREQ-1:0]  grant_d;
    logic             valid_d;
    logic             timeout_d;
    logic [SEL_W-1:0] pick;
    logic             any_req;

`ifdef MUX4_ARB_TIMEOUT_EN
    logic [TO_W-1:0]  wait_cnt_q;
    logic [TO_W-1:0]  wait_cnt_d;
`endif

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any_req)
    );

    // State, pointer and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            control <= '0;
            grant   <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            control <= control_d;
            grant   <= grant_d;
            valid   <= valid_d;
            timeout <= timeout_d;
        end
    end

`ifdef MUX4_ARB_TIMEOUT_EN
    // Stall counter for the current grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        control_d = control;
        grant_d   = '0;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = GRANT;
                    control_d = pick;
                    grant_d   = sel_onehot(pick);
                    valid_d   = 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end

            GRANT: begin
                // Hold the grant unless one of the release events below fires.
                grant_d = grant;
                valid_d = 1'b1;
                if (ready) begin
                    // Transfer wins over a same-cycle revocation.
                    state_d = IDLE;
                    ptr_d   = control + SEL_W'(1);
                    grant_d = '0;
                    valid_d = 1'b0;
                end else if (!req[control]) begin
                    // Requester withdrew: no transfer, keep its priority.
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
                end else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the last allowed stall cycle: stalled requester loses its turn.
                    state_d   = IDLE;
                    ptr_d     = control + SEL_W'(1);
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed literal checks plus a
// randomized run compared every cycle against a transaction-level model.
module tb_mux4_rr_arbiter;

    localparam int TO = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'h0;
    logic       ready = 1'b0;
    logic [1:0] control;
    logic [3:0] grant;
    logic       valid;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    // Model state: is a grant open, which index, priority start, stall count.
    bit m_busy = 1'b0;
    int m_sel  = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;
    bit m_to   = 1'b0;

    mux4_rr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .ready   (ready),
        .control (control),
        .grant   (grant),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model and per-cycle compare.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (!m_busy) begin
                if (req != 4'h0) begin
                    for (int k = 3; k >= 0; k--) begin
                        if (req[(m_ptr + k) % 4]) m_sel = (m_ptr + k) % 4;
                    end
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else if (ready) begin
                m_ptr  = (m_sel + 1) % 4;
                m_busy = 1'b0;
            end else if (!req[m_sel]) begin
                m_busy = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
            end else if (m_cnt + 1 >= TO) begin
                m_ptr  = (m_sel + 1) % 4;
                m_busy = 1'b0;
                m_to   = 1'b1;
            end else begin
                m_cnt++;
`endif
            end
            #1;
            check("model_valid",   int'(valid),   int'(m_busy));
            check("model_control", int'(control), m_sel);
            check("model_grant",   int'(grant),   m_busy ? (1 << m_sel) : 0);
            check("model_timeout", int'(timeout), int'(m_to));
        end
    end

    task automatic step(input logic [3:0] r, input logic rd);
        req   = r;
        ready = rd;
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        #1;
        check("arst_valid",   int'(valid),   0);
        check("arst_grant",   int'(grant),   0);
        check("arst_timeout", int'(timeout), 0);
        check("arst_control", int'(control), 0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int ctrl_seq [5];
        logic [3:0] r;
        ctrl_seq = '{0, 1, 2, 3, 0};

        // Reset with all requests up.
        req = 4'hF; ready = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        check("rst_control", int'(control), 0);
        check("rst_valid",   int'(valid),   0);
        check("rst_grant",   int'(grant),   0);
        @(negedge clock);
        reset_n = 1'b1;

        // Back-to-back rotation with ready held high.
        for (int i = 0; i < 10; i++) begin
            step(4'hF, 1'b1);
            if (i == 0) check("first_grant", int'(grant), 1);
            check("rot_valid", int'(valid), (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) check("rot_control", int'(control), ctrl_seq[i / 2]);
        end

        // Bring ptr to 2, then req=0011 must pick 0, then 1.
        step(4'h2, 1'b1); step(4'h2, 1'b1);
        step(4'h3, 1'b0);
        check("wrap_pick0", int'(control), 0);
        check("wrap_grant0", int'(grant), 1);
        step(4'h3, 1'b1);
        step(4'h3, 1'b0);
        check("wrap_pick1", int'(control), 1);
        step(4'h3, 1'b1);

        // Bring ptr to 3, grant 3, then revoke.
        step(4'h4, 1'b1); step(4'h4, 1'b1);
        step(4'h8, 1'b0);
        check("g3_control", int'(control), 3);
        step(4'h8, 1'b0);
        check("g3_hold", int'(valid), 1);
        step(4'h0, 1'b0);
        check("revoke_valid", int'(valid), 0);
        step(4'hF, 1'b0);
        check("revoke_ptr_kept", int'(control), 3);
        step(4'hF, 1'b1);

        // Same-cycle ready and revoke counts as a transfer.
        step(4'hF, 1'b0);
        check("sim_grant0", int'(control), 0);
        step(4'hE, 1'b1);
        step(4'hF, 1'b0);
        check("sim_ptr_adv", int'(control), 1);
        step(4'hF, 1'b1);

        // Long stall on grant 2.
        step(4'hF, 1'b0);
        check("stall_control", int'(control), 2);
`ifdef MUX4_ARB_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) begin
            step(4'hF, 1'b0);
            check("stall_valid", int'(valid), 1);
            check("stall_no_to", int'(timeout), 0);
        end
        step(4'hF, 1'b0);
        check("to_pulse", int'(timeout), 1);
        check("to_valid", int'(valid), 0);
        step(4'hF, 1'b0);
        check("to_next", int'(control), 3);
        check("to_single", int'(timeout), 0);
        step(4'hF, 1'b1);
`else
        for (int i = 0; i < 22; i++) begin
            step(4'hF, 1'b0);
            check("stall_valid", int'(valid), 1);
            check("stall_no_to", int'(timeout), 0);
        end
        step(4'hF, 1'b1);
`endif

        // Asynchronous reset in the middle of a grant.
        step(4'hF, 1'b0);
        check("pre_arst_valid", int'(valid), 1);
        pulse_reset();

        // Randomized traffic with occasional resets.
        r = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(1, 0) == 0) r = 4'($urandom);
            step(r, ($urandom_range(2, 0) == 0));
            if ($urandom_range(199, 0) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
